popcount_seq_ctrl: RTL and testbench

//   Sequencing controller for the 16-bit ones-counter datapath. Accepts one

---
 rtl/popcount_seq_ctrl.sv | 105 ++++++++++
 tb/tb_popcount_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_seq_ctrl.sv
// Sequencing controller: accepts one wide word and counts its set bits one
// SLICE_W-bit slice per cycle through a shared popcount, then offers the total.
module popcount_seq_ctrl #(
  parameter int DATA_W  = 64,
  parameter int SLICE_W = 16,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int SCNT_W = $clog2(SLICE_W + 1);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  acc;
  logic [IDX_W-1:0]  idx;
  logic [SCNT_W-1:0] slice_cnt;
  logic [CNT_W-1:0]  sum_next;
  logic              last_slice;
  logic              accept;

  always_comb begin
    slice_cnt = '0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      slice_cnt = slice_cnt + SCNT_W'(shreg[i]);
    end
  end

  assign sum_next   = acc + CNT_W'(slice_cnt);
  assign last_slice = (idx == IDX_W'(NSLICE - 1));
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)     state_next = RUN;
      RUN:  if (last_slice) state_next = DONE;
      DONE: if (out_ready)  state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Datapath only moves in IDLE (capture) and RUN (shift/accumulate); DONE holds out_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= in_data;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= sum_next;
          shreg <= shreg >> SLICE_W;
          if (last_slice) begin
            idx       <= '0;
            out_count <= sum_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Self-checking bench for popcount_seq_ctrl: table of directed words plus
// hand-written sequences for hold, ignored input, mid-run reset and streaming.
module tb_popcount_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        busy;

  int checks;
  int errors;
  int cycle;

  popcount_seq_ctrl #(.DATA_W(64), .SLICE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] data;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Presents one word, checks latency, result and the output handshake.
  task automatic send_word(input logic [63:0] data, input logic [6:0] exp, input string name);
    int n;
    @(negedge clk);
    check({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    check({name, " in_ready after accept"}, 64'(in_ready), 64'd0);
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd4);
    check({name, " out_count"}, 64'(out_count), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] words[8];
    int          n;
    int          last_acc;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = '{64'hFFFF_F56F_3FFF_0001, 7'd43};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64};
    vecs[2] = '{64'h0000_0000_0000_0000, 7'd0};
    vecs[3] = '{64'h8000_0000_0000_0001, 7'd2};
    vecs[4] = '{64'h0001_0003_0007_000F, 7'd10};
    vecs[5] = '{64'hAAAA_5555_F0F0_0F0F, 7'd32};

    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Result held in DONE while out_ready stays low
    send_word(64'h0, 7'd0, "pre-hold");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'h7ABC_7822_F10F_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold latency", 64'(n), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold out_valid c%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("hold out_count c%0d", i), 64'(out_count), 64'd25);
      check($sformatf("hold in_ready c%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release out_valid", 64'(out_valid), 64'd0);
    check("hold release in_ready", 64'(in_ready), 64'd1);

    // Input noise during RUN/DONE must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_0001;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      check($sformatf("noise busy c%0d", n), 64'(busy), 64'd1);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      n++;
    end
    check("noise latency", 64'(n), 64'd4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("noise done busy c%0d", i), 64'(busy), 64'd1);
      check($sformatf("noise done in_ready c%0d", i), 64'(in_ready), 64'd0);
    end
    check("noise out_count", 64'(out_count), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("noise back to idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("noise no extra accept", 64'(busy), 64'd0);
    check("noise count kept", 64'(out_count), 64'd1);

    // Reset asserted with idx==2 during RUN
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun rst out_valid", 64'(out_valid), 64'd0);
    check("midrun rst out_count", 64'(out_count), 64'd0);
    check("midrun rst busy", 64'(busy), 64'd0);
    check("midrun rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrun no out_valid pulse", 64'(n), 64'd0);
    send_word(64'h0F0F_0F0F_0F0F_0F0F, 7'd32, "post-reset");

    // Back-to-back stream, in_valid and out_ready held high
    words[0] = 64'hDEAD_BEEF_0123_4567;
    for (int i = 1; i < 8; i++) words[i] = {$urandom, $urandom};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("stream w%0d in_ready wait", k), 64'(in_ready), 64'd1);
      in_data = words[k];
      if (k > 0) check($sformatf("stream w%0d period", k), 64'(cycle - last_acc), 64'd6);
      last_acc = cycle;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("stream w%0d out_count", k), 64'(out_count), 64'($countones(words[k])));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
